// File: rtl/ex_unit_if.sv
// rtl/ex_unit_if.sv - issue and broadcast signal bundle between the reservation station and ex_unit
//
// Also provides the shared bus-width macros used by ex_unit.
//
// Issue side (driven by the master):
//   iRS_en, iRS_op, iRS_pc, iRS_imm, iRS_rd_nick, iRS_rs1_dt, iRS_rs2_dt
// Result side (driven by the slave):
//   oCDB_en, oCDB_nick, oCDB_dt, oROB_br, oROB_taken, oROB_target
// Modports: master = issuing reservation station, slave = ex_unit.

`ifndef OpBus
`define OpBus 5:0
`endif
`ifndef AddrBus
`define AddrBus 31:0
`endif
`ifndef ImmBus
`define ImmBus 31:0
`endif
`ifndef NickBus
`define NickBus 4:0
`endif
`ifndef DataBus
`define DataBus 31:0
`endif

interface ex_unit_if;
    logic            iRS_en;
    logic [`OpBus]   iRS_op;
    logic [`AddrBus] iRS_pc;
    logic [`ImmBus]  iRS_imm;
    logic [`NickBus] iRS_rd_nick;
    logic [`DataBus] iRS_rs1_dt;
    logic [`DataBus] iRS_rs2_dt;

    logic            oCDB_en;
    logic [`NickBus] oCDB_nick;
    logic [`DataBus] oCDB_dt;
    logic            oROB_br;
    logic            oROB_taken;
    logic [`AddrBus] oROB_target;

    modport master (
        output iRS_en, iRS_op, iRS_pc, iRS_imm, iRS_rd_nick, iRS_rs1_dt, iRS_rs2_dt,
        input  oCDB_en, oCDB_nick, oCDB_dt, oROB_br, oROB_taken, oROB_target
    );

    modport slave (
        input  iRS_en, iRS_op, iRS_pc, iRS_imm, iRS_rd_nick, iRS_rs1_dt, iRS_rs2_dt,
        output oCDB_en, oCDB_nick, oCDB_dt, oROB_br, oROB_taken, oROB_target
    );
endinterface

// File: rtl/ex_unit.sv
// rtl/ex_unit.sv - two-stage RV32I integer execute unit feeding the common data bus
//
// Ports:
//   clk          single clock, rising edge
//   rst          asynchronous active-low reset
//   rdy          global ready; 0 freezes all state
//   clr          synchronous flush, wins over rdy=0
//   bus          ex_unit_if.slave: iRS_* issue in, oCDB_*/oROB_* result out
//   oSTAT_ops    (EX_STAT_EN only) count of broadcasts
//   oSTAT_taken  (EX_STAT_EN only) count of broadcasts with a taken control transfer
//
// Optional feature macro: EX_STAT_EN.
//
// Opcode encoding on iRS_op:
//   0 NOP, 1 ADD, 2 SUB, 3 SLL, 4 SLT, 5 SLTU, 6 XOR, 7 SRL, 8 SRA, 9 OR, 10 AND,
//   11 ADDI, 12 SLTI, 13 SLTIU, 14 XORI, 15 ORI, 16 ANDI, 17 SLLI, 18 SRLI, 19 SRAI,
//   20 LUI, 21 AUIPC, 22 JAL, 23 JALR, 24 BEQ, 25 BNE, 26 BLT, 27 BGE, 28 BLTU, 29 BGEU,
//   30..37 loads/stores. Loads, stores and unknown codes produce no broadcast.

module ex_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clr,
    ex_unit_if.slave    bus
`ifdef EX_STAT_EN
    ,
    output logic [31:0] oSTAT_ops,
    output logic [31:0] oSTAT_taken
`endif
);

    localparam logic [5:0] OP_ADD   = 6'd1;
    localparam logic [5:0] OP_SUB   = 6'd2;
    localparam logic [5:0] OP_SLL   = 6'd3;
    localparam logic [5:0] OP_SLT   = 6'd4;
    localparam logic [5:0] OP_SLTU  = 6'd5;
    localparam logic [5:0] OP_XOR   = 6'd6;
    localparam logic [5:0] OP_SRL   = 6'd7;
    localparam logic [5:0] OP_SRA   = 6'd8;
    localparam logic [5:0] OP_OR    = 6'd9;
    localparam logic [5:0] OP_AND   = 6'd10;
    localparam logic [5:0] OP_ADDI  = 6'd11;
    localparam logic [5:0] OP_SLTI  = 6'd12;
    localparam logic [5:0] OP_SLTIU = 6'd13;
    localparam logic [5:0] OP_XORI  = 6'd14;
    localparam logic [5:0] OP_ORI   = 6'd15;
    localparam logic [5:0] OP_ANDI  = 6'd16;
    localparam logic [5:0] OP_SLLI  = 6'd17;
    localparam logic [5:0] OP_SRLI  = 6'd18;
    localparam logic [5:0] OP_SRAI  = 6'd19;
    localparam logic [5:0] OP_LUI   = 6'd20;
    localparam logic [5:0] OP_AUIPC = 6'd21;
    localparam logic [5:0] OP_JAL   = 6'd22;
    localparam logic [5:0] OP_JALR  = 6'd23;
    localparam logic [5:0] OP_BEQ   = 6'd24;
    localparam logic [5:0] OP_BNE   = 6'd25;
    localparam logic [5:0] OP_BLT   = 6'd26;
    localparam logic [5:0] OP_BGE   = 6'd27;
    localparam logic [5:0] OP_BLTU  = 6'd28;
    localparam logic [5:0] OP_BGEU  = 6'd29;

    logic            e1_valid;
    logic [`OpBus]   e1_op;
    logic [`AddrBus] e1_pc;
    logic [`ImmBus]  e1_imm;
    logic [`NickBus] e1_nick;
    logic [`DataBus] e1_rs1;
    logic [`DataBus] e1_rs2;

    logic [31:0]     opb;
    logic [4:0]      shamt;
    logic [31:0]     pc_plus4;
    logic [31:0]     pc_imm;
    logic [31:0]     jalr_sum;
    logic            is_branch;
    logic            res_known;
    logic [31:0]     res_dt;
    logic            res_br;
    logic            res_taken;
    logic [31:0]     res_target;
    logic            e2_fire;

    // E1: nick 0 is reserved, so such an issue never becomes valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e1_valid <= 1'b0;
            e1_op    <= '0;
            e1_pc    <= '0;
            e1_imm   <= '0;
            e1_nick  <= '0;
            e1_rs1   <= '0;
            e1_rs2   <= '0;
        end else if (clr) begin
            e1_valid <= 1'b0;
        end else if (rdy) begin
            e1_valid <= bus.iRS_en && (bus.iRS_rd_nick != '0);
            if (bus.iRS_en) begin
                e1_op   <= bus.iRS_op;
                e1_pc   <= bus.iRS_pc;
                e1_imm  <= bus.iRS_imm;
                e1_nick <= bus.iRS_rd_nick;
                e1_rs1  <= bus.iRS_rs1_dt;
                e1_rs2  <= bus.iRS_rs2_dt;
            end
        end
    end

    always_comb begin
        opb        = ((e1_op >= OP_ADDI) && (e1_op <= OP_SRAI)) ? e1_imm : e1_rs2;
        shamt      = opb[4:0];
        pc_plus4   = e1_pc + 32'd4;
        pc_imm     = e1_pc + e1_imm;
        jalr_sum   = e1_rs1 + e1_imm;
        is_branch  = (e1_op >= OP_BEQ) && (e1_op <= OP_BGEU);
        res_known  = 1'b1;
        res_dt     = '0;
        res_br     = 1'b0;
        res_taken  = 1'b0;
        res_target = pc_plus4;
        case (e1_op)
            OP_ADD, OP_ADDI:   res_dt = e1_rs1 + opb;
            OP_SUB:            res_dt = e1_rs1 - opb;
            OP_SLL, OP_SLLI:   res_dt = e1_rs1 << shamt;
            OP_SRL, OP_SRLI:   res_dt = e1_rs1 >> shamt;
            OP_SRA, OP_SRAI:   res_dt = $unsigned($signed(e1_rs1) >>> shamt);
            OP_SLT, OP_SLTI:   res_dt = {31'd0, $signed(e1_rs1) < $signed(opb)};
            OP_SLTU, OP_SLTIU: res_dt = {31'd0, e1_rs1 < opb};
            OP_XOR, OP_XORI:   res_dt = e1_rs1 ^ opb;
            OP_OR, OP_ORI:     res_dt = e1_rs1 | opb;
            OP_AND, OP_ANDI:   res_dt = e1_rs1 & opb;
            OP_LUI:            res_dt = e1_imm;
            OP_AUIPC:          res_dt = pc_imm;
            OP_JAL: begin
                res_dt     = pc_plus4;
                res_br     = 1'b1;
                res_taken  = 1'b1;
                res_target = pc_imm;
            end
            OP_JALR: begin
                res_dt     = pc_plus4;
                res_br     = 1'b1;
                res_taken  = 1'b1;
                res_target = jalr_sum & ~32'd1;
            end
            OP_BEQ:  res_taken = (e1_rs1 == e1_rs2);
            OP_BNE:  res_taken = (e1_rs1 != e1_rs2);
            OP_BLT:  res_taken = ($signed(e1_rs1) < $signed(e1_rs2));
            OP_BGE:  res_taken = ($signed(e1_rs1) >= $signed(e1_rs2));
            OP_BLTU: res_taken = (e1_rs1 < e1_rs2);
            OP_BGEU: res_taken = (e1_rs1 >= e1_rs2);
            default: res_known = 1'b0;
        endcase
        if (is_branch) begin
            res_br     = 1'b1;
            res_target = res_taken ? pc_imm : pc_plus4;
        end
    end

    assign e2_fire = e1_valid && res_known;

    // E2: the outputs are the stage register itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.oCDB_en     <= 1'b0;
            bus.oCDB_nick   <= '0;
            bus.oCDB_dt     <= '0;
            bus.oROB_br     <= 1'b0;
            bus.oROB_taken  <= 1'b0;
            bus.oROB_target <= '0;
        end else if (clr) begin
            bus.oCDB_en    <= 1'b0;
            bus.oROB_br    <= 1'b0;
            bus.oROB_taken <= 1'b0;
        end else if (rdy) begin
            bus.oCDB_en     <= e2_fire;
            bus.oCDB_nick   <= e1_nick;
            bus.oCDB_dt     <= res_dt;
            bus.oROB_br     <= e2_fire && res_br;
            bus.oROB_taken  <= e2_fire && res_taken;
            bus.oROB_target <= res_target;
        end
    end

`ifdef EX_STAT_EN
    // Counted as the broadcast is loaded into E2, so a flushed op is never counted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            oSTAT_ops   <= '0;
            oSTAT_taken <= '0;
        end else if (rdy && !clr && e2_fire) begin
            oSTAT_ops <= oSTAT_ops + 32'd1;
            if (res_taken) begin
                oSTAT_taken <= oSTAT_taken + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ex_unit.sv
// tb/tb_ex_unit.sv - directed vector bench for ex_unit
module tb_ex_unit;

    localparam logic [5:0] OP_ADD   = 6'd1;
    localparam logic [5:0] OP_SUB   = 6'd2;
    localparam logic [5:0] OP_SLL   = 6'd3;
    localparam logic [5:0] OP_SLT   = 6'd4;
    localparam logic [5:0] OP_SLTU  = 6'd5;
    localparam logic [5:0] OP_XOR   = 6'd6;
    localparam logic [5:0] OP_SRL   = 6'd7;
    localparam logic [5:0] OP_SRA   = 6'd8;
    localparam logic [5:0] OP_AND   = 6'd10;
    localparam logic [5:0] OP_ADDI  = 6'd11;
    localparam logic [5:0] OP_SLTI  = 6'd12;
    localparam logic [5:0] OP_SRAI  = 6'd19;
    localparam logic [5:0] OP_LUI   = 6'd20;
    localparam logic [5:0] OP_AUIPC = 6'd21;
    localparam logic [5:0] OP_JAL   = 6'd22;
    localparam logic [5:0] OP_JALR  = 6'd23;
    localparam logic [5:0] OP_BEQ   = 6'd24;
    localparam logic [5:0] OP_BNE   = 6'd25;
    localparam logic [5:0] OP_BGE   = 6'd27;
    localparam logic [5:0] OP_BLTU  = 6'd28;
    localparam logic [5:0] OP_LW    = 6'd32;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  nick;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        en;
        logic [31:0] dt;
        logic        br;
        logic        taken;
        logic [31:0] target;
    } vec_t;

    localparam int NV = 21;

    logic clk;
    logic rst;
    logic rdy;
    logic clr;
    int   tests;
    int   fails;
    vec_t vecs [NV];

    ex_unit_if bus ();

`ifdef EX_STAT_EN
    logic [31:0] stat_ops;
    logic [31:0] stat_taken;
`endif

    ex_unit dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .clr (clr),
        .bus (bus)
`ifdef EX_STAT_EN
        ,
        .oSTAT_ops   (stat_ops),
        .oSTAT_taken (stat_taken)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] imm,
                                input logic [4:0] nick, input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic en, input logic [31:0] dt, input logic br,
                                input logic taken, input logic [31:0] target);
        vec_t v;
        v.op = op; v.pc = pc; v.imm = imm; v.nick = nick; v.rs1 = rs1; v.rs2 = rs2;
        v.en = en; v.dt = dt; v.br = br; v.taken = taken; v.target = target;
        return v;
    endfunction

    task automatic drive(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [4:0] nick, input logic [31:0] rs1, input logic [31:0] rs2);
        bus.iRS_en      = 1'b1;
        bus.iRS_op      = op;
        bus.iRS_pc      = pc;
        bus.iRS_imm     = imm;
        bus.iRS_rd_nick = nick;
        bus.iRS_rs1_dt  = rs1;
        bus.iRS_rs2_dt  = rs2;
    endtask

    task automatic idle();
        bus.iRS_en = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // full=0 compares only the valid/flag bits (payload is don't-care when nothing is broadcast).
    task automatic check_out(input string name, input logic en, input logic [4:0] nick,
                             input logic [31:0] dt, input logic br, input logic taken,
                             input logic [31:0] target, input logic full);
        logic bad;
        tests++;
        bad = (bus.oCDB_en !== en) || (bus.oROB_br !== br) || (bus.oROB_taken !== taken);
        if (full)
            bad = bad || (bus.oCDB_nick !== nick) || (bus.oCDB_dt !== dt) || (bus.oROB_target !== target);
        if (bad) begin
            fails++;
            $display("FAIL %s: got en=%b nick=%0d dt=%h br=%b taken=%b target=%h, expected en=%b nick=%0d dt=%h br=%b taken=%b target=%h",
                     name, bus.oCDB_en, bus.oCDB_nick, bus.oCDB_dt, bus.oROB_br, bus.oROB_taken,
                     bus.oROB_target, en, nick, dt, br, taken, target);
        end
    endtask

    task automatic check_none(input string name);
        check_out(name, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic check_alu(input string name, input logic [4:0] nick, input logic [31:0] dt,
                             input logic [31:0] pc);
        check_out(name, 1'b1, nick, dt, 1'b0, 1'b0, pc + 32'd4, 1'b1);
    endtask

    initial begin
        tests = 0;
        fails = 0;

        vecs[0]  = mk(OP_ADD,   32'h0,   32'h0,        5'd3,  32'd5,        32'd7,        1, 32'd12,       0, 0, 32'h4);
        vecs[1]  = mk(OP_SUB,   32'h10,  32'h0,        5'd4,  32'd3,        32'd5,        1, 32'hFFFFFFFE, 0, 0, 32'h14);
        vecs[2]  = mk(OP_SLT,   32'h20,  32'h0,        5'd5,  32'hFFFFFFFF, 32'd1,        1, 32'd1,        0, 0, 32'h24);
        vecs[3]  = mk(OP_SLTU,  32'h24,  32'h0,        5'd6,  32'hFFFFFFFF, 32'd1,        1, 32'd0,        0, 0, 32'h28);
        vecs[4]  = mk(OP_SRA,   32'h28,  32'h0,        5'd7,  32'h80000000, 32'h21,       1, 32'hC0000000, 0, 0, 32'h2C);
        vecs[5]  = mk(OP_SRL,   32'h2C,  32'h0,        5'd8,  32'h80000000, 32'h21,       1, 32'h40000000, 0, 0, 32'h30);
        vecs[6]  = mk(OP_SLL,   32'h0,   32'h0,        5'd9,  32'd1,        32'd31,       1, 32'h80000000, 0, 0, 32'h4);
        vecs[7]  = mk(OP_ADDI,  32'h0,   32'h1,        5'd10, 32'hFFFFFFFF, 32'd99,       1, 32'h0,        0, 0, 32'h4);
        vecs[8]  = mk(OP_XOR,   32'h0,   32'h0,        5'd11, 32'hF0F0,     32'hFF00,     1, 32'h0FF0,     0, 0, 32'h4);
        vecs[9]  = mk(OP_LUI,   32'h200, 32'h12345000, 5'd12, 32'h0,        32'h0,        1, 32'h12345000, 0, 0, 32'h204);
        vecs[10] = mk(OP_AUIPC, 32'h200, 32'h1000,     5'd13, 32'h0,        32'h0,        1, 32'h1200,     0, 0, 32'h204);
        vecs[11] = mk(OP_BNE,   32'h100, 32'h20,       5'd14, 32'd4,        32'd4,        1, 32'h0,        1, 0, 32'h104);
        vecs[12] = mk(OP_BLTU,  32'h100, 32'h20,       5'd15, 32'd1,        32'd2,        1, 32'h0,        1, 1, 32'h120);
        vecs[13] = mk(OP_BGE,   32'h100, 32'h20,       5'd16, 32'hFFFFFFFF, 32'd1,        1, 32'h0,        1, 0, 32'h104);
        vecs[14] = mk(OP_JALR,  32'h40,  32'h4,        5'd17, 32'h1003,     32'h0,        1, 32'h44,       1, 1, 32'h1006);
        vecs[15] = mk(OP_JAL,   32'h40,  32'hFFFFFFF0, 5'd18, 32'h0,        32'h0,        1, 32'h44,       1, 1, 32'h30);
        vecs[16] = mk(OP_LW,    32'h0,   32'h0,        5'd19, 32'd1,        32'd1,        0, 32'h0,        0, 0, 32'h0);
        vecs[17] = mk(OP_ADD,   32'h0,   32'h0,        5'd0,  32'd1,        32'd1,        0, 32'h0,        0, 0, 32'h0);
        vecs[18] = mk(OP_SLTI,  32'h0,   32'hFFFFFFFF, 5'd20, 32'hFFFFFFFE, 32'h0,        1, 32'd1,        0, 0, 32'h4);
        vecs[19] = mk(OP_AND,   32'h0,   32'h0,        5'd21, 32'hFF00FF00, 32'h0FF00FF0, 1, 32'h0F000F00, 0, 0, 32'h4);
        vecs[20] = mk(OP_SRAI,  32'h0,   32'h4,        5'd22, 32'hF0000000, 32'h0,        1, 32'hFF000000, 0, 0, 32'h4);

        // Reset held with an issue pending.
        rst = 1'b0;
        rdy = 1'b1;
        clr = 1'b0;
        drive(OP_ADD, 32'h0, 32'h0, 5'd3, 32'd5, 32'd7);
        repeat (3) step();
        check_out("reset_state", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);

        // Latency: one op after release appears two edges later for one cycle.
        rst = 1'b1;
        drive(OP_ADD, 32'h0, 32'h0, 5'd3, 32'd5, 32'd7);
        step();
        idle();
        check_none("latency_edge1");
        step();
        check_alu("latency_edge2", 5'd3, 32'd12, 32'h0);
        step();
        check_none("latency_edge3");

        // Table, issued back to back.
        for (int i = 0; i <= NV; i++) begin
            if (i < NV)
                drive(vecs[i].op, vecs[i].pc, vecs[i].imm, vecs[i].nick, vecs[i].rs1, vecs[i].rs2);
            else
                idle();
            step();
            if (i >= 1)
                check_out($sformatf("vec%0d", i - 1), vecs[i-1].en, vecs[i-1].nick, vecs[i-1].dt,
                          vecs[i-1].br, vecs[i-1].taken, vecs[i-1].target, vecs[i-1].en);
        end
        idle();
        step();

        // Stall: rdy low for 3 cycles with B on the bus and C waiting in E1.
        drive(OP_ADD, 32'h0, 32'h0, 5'd1, 32'd1, 32'd1);
        step();
        drive(OP_ADD, 32'h0, 32'h0, 5'd2, 32'd2, 32'd2);
        step();
        check_alu("stall_a", 5'd1, 32'd2, 32'h0);
        drive(OP_ADD, 32'h0, 32'h0, 5'd3, 32'd3, 32'd3);
        step();
        check_alu("stall_b", 5'd2, 32'd4, 32'h0);
        idle();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_alu($sformatf("stall_hold%0d", i), 5'd2, 32'd4, 32'h0);
        end
        rdy = 1'b1;
        step();
        check_alu("stall_c", 5'd3, 32'd6, 32'h0);
        step();
        check_none("stall_after");

        // Flush: clr on the second issue cycle kills op 1 and op 2.
        drive(OP_ADD, 32'h0, 32'h0, 5'd1, 32'd10, 32'd10);
        step();
        drive(OP_ADD, 32'h0, 32'h0, 5'd2, 32'd20, 32'd20);
        clr = 1'b1;
        step();
        clr = 1'b0;
        idle();
        check_none("flush_edge1");
        step();
        check_none("flush_edge2");
        step();
        check_none("flush_edge3");

        // clr wins over rdy=0 with a taken branch on the bus.
        drive(OP_BLTU, 32'h100, 32'h20, 5'd5, 32'd1, 32'd2);
        step();
        idle();
        step();
        check_out("clr_pre", 1'b1, 5'd5, 32'd0, 1'b1, 1'b1, 32'h120, 1'b1);
        rdy = 1'b0;
        clr = 1'b1;
        step();
        check_none("clr_over_rdy");
        rdy = 1'b1;
        clr = 1'b0;

        // Asynchronous reset while a result is on the bus.
        drive(OP_ADD, 32'h0, 32'h0, 5'd6, 32'd1, 32'd2);
        step();
        idle();
        step();
        check_alu("midrst_pre", 5'd6, 32'd3, 32'h0);
        #2;
        rst = 1'b0;
        #1;
        check_out("midrst_async", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        step();
        rst = 1'b1;
        step();

`ifdef EX_STAT_EN
        // 6 ALU ops and 4 taken branches, counters fresh from the reset above.
        for (int i = 0; i < 10; i++) begin
            if (i % 3 == 1)
                drive(OP_BLTU, 32'h100, 32'h20, 5'd7, 32'd1, 32'd2);
            else if (i == 9)
                drive(OP_BEQ, 32'h100, 32'h20, 5'd8, 32'd4, 32'd4);
            else
                drive(OP_ADD, 32'h0, 32'h0, 5'd9, 32'd1, 32'd1);
            step();
        end
        idle();
        repeat (3) step();
        tests++;
        if (stat_ops !== 32'd10 || stat_taken !== 32'd4) begin
            fails++;
            $display("FAIL stat_count: got ops=%0d taken=%0d, expected ops=10 taken=4", stat_ops, stat_taken);
        end
        drive(OP_BLTU, 32'h100, 32'h20, 5'd7, 32'd1, 32'd2);
        clr = 1'b1;
        step();
        clr = 1'b0;
        idle();
        repeat (3) step();
        tests++;
        if (stat_ops !== 32'd10 || stat_taken !== 32'd4) begin
            fails++;
            $display("FAIL stat_after_clr: got ops=%0d taken=%0d, expected ops=10 taken=4", stat_ops, stat_taken);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
